// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Optional fetch-fairness counter is compiled in with `define ARB_FETCH_FAIRNESS_EN.
module imem_dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   grant;
  logic   grant_fetch;
  logic   complete;

  assign grant    = (state == IDLE) && (i_req || d_req);
  assign complete = (state == BUSY) && mem_ready;

`ifdef ARB_FETCH_FAIRNESS_EN
  // Counts data grants taken while fetch was waiting; at the limit fetch jumps the queue.
  localparam int CNT_W = $clog2(FAIR_LIMIT + 2);

  logic [CNT_W-1:0] fair_cnt;
  logic             fair_hit;

  assign fair_hit    = (fair_cnt == CNT_W'(FAIR_LIMIT));
  assign grant_fetch = ~d_req | (i_req & fair_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fair_cnt <= '0;
    end else if (grant) begin
      if (grant_fetch) begin
        fair_cnt <= '0;
      end else if (i_req && (fair_cnt < CNT_W'(FAIR_LIMIT))) begin
        fair_cnt <= fair_cnt + 1'b1;
      end
    end
  end
`else
  assign grant_fetch = ~d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory port is launched on the grant and held untouched until the memory completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
    end else if (grant) begin
      mem_req <= 1'b1;
      owner   <= ~grant_fetch;
      if (grant_fetch) begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end else begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end
    end else if (complete) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (complete) begin
      if (owner) begin
        d_rdata <= mem_rdata;
      end else begin
        i_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    i_done  = (state == RESP) && !owner;
    d_done  = (state == RESP) && owner;
    stall_f = i_req && !i_done;
    stall_m = d_req && !d_done;
  end

endmodule
